// File: rtl/uart_aes_frame_ctrl.sv
// uart_aes_frame_ctrl
// Command/frame sequencer sitting between a UART byte receiver and an
// AES-128 core. A command byte selects the destination (key or plaintext),
// the following 16 bytes are assembled MSB-first, a complete plaintext frame
// launches the core, and the 16-byte ciphertext is streamed back out through
// a start/busy transmitter handshake. Partial frames are dropped after an
// inter-byte timeout.
//
// Ports:
//   uart_clock, uart_reset  clock, asynchronous active-high reset
//   rx_data, rx_valid       received byte and its level valid (rising edge = byte)
//   aes_key, aes_data       assembled key / plaintext registers
//   aes_start               one-cycle start pulse to the AES core
//   aes_done, aes_result    completion pulse and ciphertext from the AES core
//   tx_data, tx_start       byte and one-cycle request to the transmitter
//   tx_busy                 transmitter busy
//   key_valid               a full key has been loaded since reset
//   frame_error             one-cycle pulse: timeout, or data command without key
//   busy                    sequencer is not idle
module uart_aes_frame_ctrl #(
  parameter logic [23:0] timeout_cycles = 24'd500000,
  parameter logic [7:0]  cmd_key        = 8'hA5,
  parameter logic [7:0]  cmd_data       = 8'h5A
) (
  input  logic         uart_clock,
  input  logic         uart_reset,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [127:0] aes_key,
  output logic [127:0] aes_data,
  output logic         aes_start,
  input  logic         aes_done,
  input  logic [127:0] aes_result,
  output logic [7:0]   tx_data,
  output logic         tx_start,
  input  logic         tx_busy,
  output logic         key_valid,
  output logic         frame_error,
  output logic         busy
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RX_PAYLOAD = 3'd1,
    START_AES  = 3'd2,
    WAIT_AES   = 3'd3,
    TX_LOAD    = 3'd4,
    TX_ACK     = 3'd5,
    TX_DRAIN   = 3'd6
  } state_t;

  state_t         state_q, state_d;
  logic           rx_valid_q;
  logic           dest_data_q, dest_data_d;   // 1: plaintext frame, 0: key frame
  logic [3:0]     byte_cnt_q, byte_cnt_d;
  logic [127:0]   shift_q, shift_d;
  logic [23:0]    timeout_q, timeout_d;
  logic [127:0]   aes_key_q, aes_key_d;
  logic [127:0]   aes_data_q, aes_data_d;
  logic           key_valid_q, key_valid_d;
  logic           aes_start_q, aes_start_d;
  logic           frame_error_q, frame_error_d;
  logic [127:0]   tx_shift_q, tx_shift_d;
  logic [3:0]     tx_cnt_q, tx_cnt_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           tx_start_q, tx_start_d;

  logic           rx_evt_s;
  logic [127:0]   assembled_s;

  // A level held high on rx_valid yields a single byte event.
  assign rx_evt_s    = rx_valid & ~rx_valid_q;
  assign assembled_s = {shift_q[119:0], rx_data};

  // Next-state and next-register computation for the sequencer.
  always_comb begin
    state_d       = state_q;
    dest_data_d   = dest_data_q;
    byte_cnt_d    = byte_cnt_q;
    shift_d       = shift_q;
    timeout_d     = timeout_q;
    aes_key_d     = aes_key_q;
    aes_data_d    = aes_data_q;
    key_valid_d   = key_valid_q;
    aes_start_d   = 1'b0;
    frame_error_d = 1'b0;
    tx_shift_d    = tx_shift_q;
    tx_cnt_d      = tx_cnt_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_evt_s && (rx_data == cmd_key)) begin
          dest_data_d = 1'b0;
          byte_cnt_d  = 4'd0;
          timeout_d   = 24'd0;
          state_d     = RX_PAYLOAD;
        end else if (rx_evt_s && (rx_data == cmd_data)) begin
          if (key_valid_q) begin
            dest_data_d = 1'b1;
            byte_cnt_d  = 4'd0;
            timeout_d   = 24'd0;
            state_d     = RX_PAYLOAD;
          end else begin
            frame_error_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end

      RX_PAYLOAD: begin
        // A byte arriving in the timeout cycle wins over the timeout.
        if (rx_evt_s) begin
          shift_d    = assembled_s;
          byte_cnt_d = byte_cnt_q + 4'd1;
          timeout_d  = 24'd0;
          if (byte_cnt_q == 4'd15) begin
            if (dest_data_q) begin
              aes_data_d  = assembled_s;
              aes_start_d = 1'b1;
              state_d     = START_AES;
            end else begin
              aes_key_d   = assembled_s;
              key_valid_d = 1'b1;
              state_d     = IDLE;
            end
          end else begin
            state_d = RX_PAYLOAD;
          end
        end else if (timeout_q == (timeout_cycles - 24'd1)) begin
          frame_error_d = 1'b1;
          timeout_d     = 24'd0;
          state_d       = IDLE;
        end else begin
          timeout_d = timeout_q + 24'd1;
        end
      end

      START_AES: begin
        state_d = WAIT_AES;
      end

      WAIT_AES: begin
        if (aes_done) begin
          tx_shift_d = aes_result;
          tx_cnt_d   = 4'd0;
          state_d    = TX_LOAD;
        end else begin
          state_d = WAIT_AES;
        end
      end

      TX_LOAD: begin
        if (!tx_busy) begin
          tx_data_d  = tx_shift_q[127:120];
          tx_start_d = 1'b1;
          state_d    = TX_ACK;
        end else begin
          state_d = TX_LOAD;
        end
      end

      TX_ACK: begin
        if (tx_busy) begin
          state_d = TX_DRAIN;
        end else begin
          state_d = TX_ACK;
        end
      end

      TX_DRAIN: begin
        if (!tx_busy) begin
          tx_shift_d = {tx_shift_q[119:0], 8'h00};
          tx_cnt_d   = tx_cnt_q + 4'd1;
          if (tx_cnt_q == 4'd15) begin
            state_d = IDLE;
          end else begin
            state_d = TX_LOAD;
          end
        end else begin
          state_d = TX_DRAIN;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything including key_valid.
  always_ff @(posedge uart_clock or posedge uart_reset) begin
    if (uart_reset) begin
      state_q       <= IDLE;
      rx_valid_q    <= 1'b0;
      dest_data_q   <= 1'b0;
      byte_cnt_q    <= 4'd0;
      shift_q       <= 128'd0;
      timeout_q     <= 24'd0;
      aes_key_q     <= 128'd0;
      aes_data_q    <= 128'd0;
      key_valid_q   <= 1'b0;
      aes_start_q   <= 1'b0;
      frame_error_q <= 1'b0;
      tx_shift_q    <= 128'd0;
      tx_cnt_q      <= 4'd0;
      tx_data_q     <= 8'd0;
      tx_start_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_valid_q    <= rx_valid;
      dest_data_q   <= dest_data_d;
      byte_cnt_q    <= byte_cnt_d;
      shift_q       <= shift_d;
      timeout_q     <= timeout_d;
      aes_key_q     <= aes_key_d;
      aes_data_q    <= aes_data_d;
      key_valid_q   <= key_valid_d;
      aes_start_q   <= aes_start_d;
      frame_error_q <= frame_error_d;
      tx_shift_q    <= tx_shift_d;
      tx_cnt_q      <= tx_cnt_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
    end
  end

  assign aes_key     = aes_key_q;
  assign aes_data    = aes_data_q;
  assign aes_start   = aes_start_q;
  assign key_valid   = key_valid_q;
  assign frame_error = frame_error_q;
  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_aes_frame_ctrl.sv
// Self-checking bench for uart_aes_frame_ctrl: a table of command frames with
// hand-computed results, plus hand-written sequences for encrypt/transmit,
// level-held rx_valid and reset during transmission.
module tb_uart_aes_frame_ctrl;

  localparam logic [23:0] TMO = 24'd100;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   rx_data = 8'd0;
  logic         rx_valid = 1'b0;
  logic [127:0] aes_key, aes_data;
  logic         aes_start;
  logic         aes_done = 1'b0;
  logic [127:0] aes_result = 128'd0;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic         tx_busy = 1'b0;
  logic         key_valid, frame_error, busy;

  int n_cmp = 0;
  int n_fail = 0;

  // monitor-owned counters
  int err_cnt = 0;
  int start_cnt = 0;
  int tx_total = 0;
  int busy_left = 0;
  logic [7:0] tx_log [0:63];

  uart_aes_frame_ctrl #(
    .timeout_cycles(TMO),
    .cmd_key(8'hA5),
    .cmd_data(8'h5A)
  ) dut (
    .uart_clock(clk),
    .uart_reset(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .aes_key(aes_key),
    .aes_data(aes_data),
    .aes_start(aes_start),
    .aes_done(aes_done),
    .aes_result(aes_result),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .tx_busy(tx_busy),
    .key_valid(key_valid),
    .frame_error(frame_error),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse counters and transmitter model: busy for 10 cycles after each tx_start.
  always @(negedge clk) begin
    if (frame_error) err_cnt = err_cnt + 1;
    if (aes_start) start_cnt = start_cnt + 1;
    if (tx_start) begin
      tx_log[tx_total % 64] = tx_data;
      tx_total  = tx_total + 1;
      tx_busy   = 1'b1;
      busy_left = 10;
    end else if (busy_left > 0) begin
      busy_left = busy_left - 1;
      if (busy_left == 0) tx_busy = 1'b0;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]   cmd;
    logic [7:0]   first;
    logic [7:0]   step;
    int           nbytes;
    logic [127:0] exp_key;
    logic         exp_kv;
    logic [127:0] exp_data;
    int           exp_err;
    int           exp_start;
  } vec_t;

  vec_t vecs [0:5];

  initial begin
    int e0, s0, t0, k;
    logic [7:0] b;
    logic [127:0] res;
    logic [127:0] key2;

    key2 = 128'h102132435465768798A9BACBDCEDFE0F;
    // cmd, first, step, n, key, kv, data, err, start
    vecs[0] = '{8'h5A, 8'h00, 8'h00, 0,  128'd0, 1'b0, 128'd0, 1, 0};  // data with no key
    vecs[1] = '{8'h33, 8'h00, 8'h00, 0,  128'd0, 1'b0, 128'd0, 0, 0};  // garbage ignored
    vecs[2] = '{8'hA5, 8'h00, 8'h01, 16, 128'h000102030405060708090A0B0C0D0E0F, 1'b1, 128'd0, 0, 0};
    vecs[3] = '{8'hA5, 8'hF0, 8'h01, 5,  128'h000102030405060708090A0B0C0D0E0F, 1'b1, 128'd0, 1, 0};  // timeout
    vecs[4] = '{8'hA5, 8'h10, 8'h11, 16, key2, 1'b1, 128'd0, 0, 0};
    vecs[5] = '{8'h5A, 8'h11, 8'h00, 5,  key2, 1'b1, 128'd0, 1, 0};   // partial data frame

    // reset state
    repeat (3) @(negedge clk);
    check("rst_key", aes_key, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_outs", {tx_data, tx_start, aes_start, key_valid, frame_error, busy}, 128'd0);
    check("post_rst_data", aes_data, 128'd0);

    // table-driven frames
    for (int v = 0; v < 6; v++) begin
      e0 = err_cnt;
      s0 = start_cnt;
      send_byte(vecs[v].cmd);
      for (int i = 0; i < vecs[v].nbytes; i++) begin
        b = vecs[v].first + (8'(i) * vecs[v].step);
        send_byte(b);
      end
      repeat (3 * int'(TMO)) @(negedge clk);
      check($sformatf("v%0d_key", v), aes_key, vecs[v].exp_key);
      check($sformatf("v%0d_kv", v), {127'd0, key_valid}, {127'd0, vecs[v].exp_kv});
      check($sformatf("v%0d_data", v), aes_data, vecs[v].exp_data);
      check($sformatf("v%0d_err", v), 128'(err_cnt - e0), 128'(vecs[v].exp_err));
      check($sformatf("v%0d_start", v), 128'(start_cnt - s0), 128'(vecs[v].exp_start));
      check($sformatf("v%0d_busy", v), {127'd0, busy}, 128'd0);
    end

    // encrypt and stream the ciphertext out
    s0 = start_cnt;
    t0 = tx_total;
    send_byte(8'h5A);
    for (int i = 0; i < 15; i++) send_byte(8'h11);
    @(negedge clk);
    rx_data  = 8'h11;
    rx_valid = 1'b1;
    @(negedge clk);
    check("start_pulse", {127'd0, aes_start}, 128'd1);
    check("enc_data", aes_data, {16{8'h11}});
    rx_valid = 1'b0;
    @(negedge clk);
    check("start_one_cycle", {127'd0, aes_start}, 128'd0);
    repeat (5) @(negedge clk);
    check("wait_aes_busy", {127'd0, busy}, 128'd1);
    check("start_count", 128'(start_cnt - s0), 128'd1);
    res = {4{32'hDEADBEEF}};
    aes_result = res;
    aes_done   = 1'b1;
    @(negedge clk);
    aes_done   = 1'b0;
    aes_result = 128'd0;
    k = 0;
    while ((tx_total - t0 < 16) && (k < 2000)) begin
      @(negedge clk);
      k++;
    end
    check("tx_timeout", 128'(tx_total - t0), 128'd16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("tx_byte%0d", i), {120'd0, tx_log[(t0 + i) % 64]}, {120'd0, res[127 - 8*i -: 8]});
    end
    k = 0;
    while (busy && (k < 500)) begin
      @(negedge clk);
      k++;
    end
    check("tx_done_idle", {127'd0, busy}, 128'd0);
    check("tx_last_hold", {120'd0, tx_data}, 128'hEF);
    check("tx_total_after", 128'(tx_total - t0), 128'd16);

    // level-held rx_valid counts as a single byte
    e0 = err_cnt;
    send_byte(8'hA5);
    @(negedge clk);
    rx_data  = 8'hAA;
    rx_valid = 1'b1;
    repeat (50) @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    for (int i = 1; i < 15; i++) send_byte(8'(i));
    check("level_still_busy", {127'd0, busy}, 128'd1);
    send_byte(8'h0F);
    check("level_key", aes_key, 128'hAA0102030405060708090A0B0C0D0E0F);
    check("level_idle", {127'd0, busy}, 128'd0);
    check("level_no_err", 128'(err_cnt - e0), 128'd0);

    // reset while draining the 7th transmitted byte
    t0 = tx_total;
    send_byte(8'h5A);
    for (int i = 0; i < 16; i++) send_byte(8'(i) + 8'h40);
    repeat (3) @(negedge clk);
    aes_result = {16{8'h3C}};
    aes_done   = 1'b1;
    @(negedge clk);
    aes_done = 1'b0;
    k = 0;
    while ((tx_total - t0 < 7) && (k < 2000)) begin
      @(negedge clk);
      k++;
    end
    check("rst_mid_reach7", 128'(tx_total - t0), 128'd7);
    repeat (3) @(negedge clk);
    check("rst_mid_busy_before", {127'd0, busy}, 128'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_key", aes_key, 128'd0);
    check("rst_mid_data", aes_data, 128'd0);
    check("rst_mid_outs", {tx_data, tx_start, aes_start, key_valid, frame_error, busy}, 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_mid_idle", {126'd0, busy, key_valid}, 128'd0);
    e0 = err_cnt;
    send_byte(8'h5A);
    repeat (3) @(negedge clk);
    check("rst_mid_nokey_err", 128'(err_cnt - e0), 128'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
